// File: rtl/mul_sequencer.sv
// mul_sequencer: iterative shift-and-add multiplier for the RV32M MUL instruction.
// One partial product is accumulated per RUN cycle. The pipeline is stalled
// while a multiply is pending or running. The result is the low 32 bits of the
// product.
// Optional build macro MUL_EARLY_TERM_EN: leave RUN as soon as the remaining
// multiplier bits are all zero. The result is the same; only the latency changes.

module mul_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mul_req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [4:0]  count_q, count_d;

  // One shift-and-add iteration, computed from the current register values
  logic [31:0] step_acc_s;
  logic [31:0] step_mcand_s;
  logic [31:0] step_mplier_s;
  logic [4:0]  step_count_s;
  logic        step_last_s;

  // Compute the accumulate/shift values for a single RUN iteration
  always_comb begin
    step_acc_s    = acc_q;
    step_mcand_s  = mcand_q << 1;
    step_mplier_s = mplier_q >> 1;
    step_count_s  = count_q;
    step_last_s   = 1'b0;
    if (mplier_q[0]) begin
      step_acc_s = acc_q + mcand_q;
    end else begin
      step_acc_s = acc_q;
    end
    // The count saturates at 31, because the FSM leaves RUN after that iteration
    if (count_q == 5'd31) begin
      step_count_s = count_q;
      step_last_s  = 1'b1;
    end else begin
      step_count_s = count_q + 5'd1;
      step_last_s  = 1'b0;
    end
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        if (mul_req) begin
          state_d  = S_RUN;
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = 32'd0;
          count_d  = 5'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
`ifdef MUL_EARLY_TERM_EN
        if (mplier_q == 32'd0) begin
          // No multiplier bits remain, so later iterations would add nothing
          state_d = S_DONE;
        end else begin
          acc_d    = step_acc_s;
          mcand_d  = step_mcand_s;
          mplier_d = step_mplier_s;
          count_d  = step_count_s;
          if (step_last_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
`else
        acc_d    = step_acc_s;
        mcand_d  = step_mcand_s;
        mplier_d = step_mplier_s;
        count_d  = step_count_s;
        if (step_last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      count_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  // Status is decoded from the state register. All outputs are forced quiet while reset is held.
  // stall must respond in the same cycle as a request from IDLE, so it also depends on mul_req.
  assign stall  = rst_n & (((state_q == S_IDLE) & mul_req) | (state_q == S_RUN));
  assign busy   = rst_n & (state_q == S_RUN);
  assign done   = rst_n & (state_q == S_DONE);
  assign result = rst_n ? acc_q : 32'd0;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed and random MUL operations. Each result is checked against
// the arithmetic product, and the stall/busy/done timing against the expected latency.

module tb_mul_sequencer;

  logic        clk;
  logic        rst_n;
  logic        mul_req;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int failures;

  mul_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mul_req (mul_req),
    .op_a    (op_a),
    .op_b    (op_b),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Cycle in which done is expected, counting the request cycle as 0
  function automatic int exp_latency(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    int msb;
    int lat;
    msb = -1;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) msb = i;
    end
    lat = 2 + msb + 1;
    if (lat > 33) lat = 33;
    return lat;
`else
    return 33;
`endif
  endfunction

  // One full MUL. Operands and mul_req are scrambled during RUN. Optionally a
  // back-to-back request is presented in the done cycle.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit force9, input bit chain,
                        input logic [31:0] na, input logic [31:0] nb);
    int lat;
    logic [31:0] expr;
    lat  = exp_latency(b);
    expr = a * b;
    @(posedge clk); #1;
    op_a = a; op_b = b; mul_req = 1'b1;
    @(negedge clk);
    check({tag, "/c0_stall"}, {31'd0, stall}, 32'd1);
    check({tag, "/c0_busy"},  {31'd0, busy},  32'd0);
    check({tag, "/c0_done"},  {31'd0, done},  32'd0);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c < lat) begin
        op_a    = $urandom;
        op_b    = force9 ? 32'd9 : $urandom;
        mul_req = 1'($urandom_range(0, 1));
      end else if (chain) begin
        op_a = na; op_b = nb; mul_req = 1'b1;
      end else begin
        mul_req = 1'b0;
      end
      @(negedge clk);
      check($sformatf("%s/c%0d_stall", tag, c), {31'd0, stall}, {31'd0, (c < lat)});
      check($sformatf("%s/c%0d_busy", tag, c),  {31'd0, busy},  {31'd0, (c < lat)});
      check($sformatf("%s/c%0d_done", tag, c),  {31'd0, done},  {31'd0, (c == lat)});
      if (c == lat) check({tag, "/result"}, result, expr);
    end
    if (!chain) begin
      @(posedge clk); #1;
      op_a = $urandom; op_b = $urandom;
      @(negedge clk);
      check({tag, "/hold_result"}, result, expr);
      check({tag, "/idle_done"},   {31'd0, done},  32'd0);
      check({tag, "/idle_stall"},  {31'd0, stall}, 32'd0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    mul_req  = 1'b1;
    op_a     = 32'd7;
    op_b     = 32'd6;

    // Reset held with a request pending: every output stays quiet
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/stall",  {31'd0, stall}, 32'd0);
    check("rst/busy",   {31'd0, busy},  32'd0);
    check("rst/done",   {31'd0, done},  32'd0);
    check("rst/result", result,         32'd0);
    @(posedge clk); #1;
    mul_req = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("post_rst/stall",  {31'd0, stall}, 32'd0);
    check("post_rst/busy",   {31'd0, busy},  32'd0);
    check("post_rst/result", result,         32'd0);

    // Directed operations
    run_op("m7x6",   32'd7,          32'd6,          1'b0, 1'b0, 32'd0, 32'd0);
    run_op("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'd0);
    run_op("wrap",   32'h8000_0000, 32'd2,          1'b1, 1'b0, 32'd0, 32'd0);
    run_op("b2b_1",  32'd3,          32'd5,          1'b0, 1'b1, 32'd4, 32'd4);
    run_op("b2b_2",  32'd4,          32'd4,          1'b0, 1'b0, 32'd0, 32'd0);
    run_op("bzero",  32'h1234_5678, 32'd0,          1'b0, 1'b0, 32'd0, 32'd0);
    run_op("m5x3",   32'd5,          32'd3,          1'b0, 1'b0, 32'd0, 32'd0);
    run_op("bmsb",   32'h0000_0003, 32'h8000_0001, 1'b0, 1'b0, 32'd0, 32'd0);

    // Random operands
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i == 2) ? 32'($urandom_range(0, 255)) : $urandom;
      run_op($sformatf("rnd%0d", i), ra, rb, 1'b0, 1'b0, 32'd0, 32'd0);
    end

    // Reset during RUN cycle 10 aborts the operation without a done pulse
    @(posedge clk); #1;
    op_a = 32'd123; op_b = 32'hFFFF_FFFF; mul_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      mul_req = 1'b0;
      if (c == 10) rst_n = 1'b0;
      @(negedge clk);
      if (c < 10) check($sformatf("abort/c%0d_busy", c), {31'd0, busy}, 32'd1);
    end
    check("abort/rst_stall", {31'd0, stall}, 32'd0);
    check("abort/rst_done",  {31'd0, done},  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort/busy",   {31'd0, busy},  32'd0);
    check("abort/stall",  {31'd0, stall}, 32'd0);
    check("abort/result", result,         32'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check($sformatf("abort/nodone%0d", c), {31'd0, done}, 32'd0);
    end

    // The sequencer still works after an aborted operation
    run_op("after_abort", 32'd11, 32'd13, 1'b0, 1'b0, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
